// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: frequency sweep sequencer for a DDS core.
//
// On an accepted start the sweep configuration is latched and the block steps the
// frequency word from f_start towards f_stop in f_step increments, holding each word
// for dwell+1 cycles. Modes: 0 single up-ramp, 1 continuous sawtooth, 2 triangle.
//
// Ports:
//   clk, rstn            clock (rising edge), synchronous active-low reset
//   start, abort         one-cycle sweep request (IDLE only), sweep termination
//   mode                 sweep mode, 3 is rejected
//   f_start/f_stop/f_step  sweep frequency words, unsigned
//   dwell                hold count, each word is held dwell+1 cycles
//   pword_in             phase offset latched at start
//   fword, pword         registered frequency/phase words to the DDS
//   busy                 high while a sweep runs
//   done, err, step_strobe  one-cycle status pulses
module dds_sweep_ctrl #(
    parameter int unsigned DEPTH_BITWIDTH = 8,
    parameter int unsigned DWELL_BITWIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic                      abort,
    input  logic [1:0]                mode,
    input  logic [DEPTH_BITWIDTH-1:0] f_start,
    input  logic [DEPTH_BITWIDTH-1:0] f_stop,
    input  logic [DEPTH_BITWIDTH-1:0] f_step,
    input  logic [DWELL_BITWIDTH-1:0] dwell,
    input  logic [DEPTH_BITWIDTH-1:0] pword_in,
    output logic [DEPTH_BITWIDTH-1:0] fword,
    output logic [DEPTH_BITWIDTH-1:0] pword,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      step_strobe
);

    localparam logic [DWELL_BITWIDTH-1:0] CntOne = 1;

    typedef enum logic [1:0] {StIdle, StUp, StDown} state_e;

    state_e                    state_q, state_d;
    logic [DEPTH_BITWIDTH-1:0] fword_q, fword_d;
    logic [DEPTH_BITWIDTH-1:0] pword_q, pword_d;
    logic [DWELL_BITWIDTH-1:0] cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic                      strobe_q, strobe_d;

    // Latched sweep configuration
    logic [1:0]                cfg_mode_q, cfg_mode_d;
    logic [DEPTH_BITWIDTH-1:0] cfg_fstart_q, cfg_fstart_d;
    logic [DEPTH_BITWIDTH-1:0] cfg_fstop_q, cfg_fstop_d;
    logic [DEPTH_BITWIDTH-1:0] cfg_fstep_q, cfg_fstep_d;
    logic [DWELL_BITWIDTH-1:0] cfg_dwell_q, cfg_dwell_d;

    // One extra bit so neither the upward sum nor the downward bound can wrap.
    logic [DEPTH_BITWIDTH:0]   up_sum;
    logic [DEPTH_BITWIDTH:0]   down_floor;
    logic [DEPTH_BITWIDTH-1:0] down_diff;
    logic                      up_ok;
    logic                      down_ok;
    logic                      start_ok;

    always_comb begin
        up_sum     = {1'b0, fword_q} + {1'b0, cfg_fstep_q};
        down_floor = {1'b0, cfg_fstart_q} + {1'b0, cfg_fstep_q};
        down_diff  = fword_q - cfg_fstep_q;
        up_ok      = (up_sum <= {1'b0, cfg_fstop_q});
        // fword - f_step >= f_start, rearranged to avoid a negative intermediate
        down_ok    = ({1'b0, fword_q} >= down_floor);
        start_ok   = (f_step != '0) && (f_stop >= f_start) && (mode != 2'd3);
    end

    always_comb begin
        state_d      = state_q;
        fword_d      = fword_q;
        pword_d      = pword_q;
        cnt_d        = cnt_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        strobe_d     = 1'b0;
        cfg_mode_d   = cfg_mode_q;
        cfg_fstart_d = cfg_fstart_q;
        cfg_fstop_d  = cfg_fstop_q;
        cfg_fstep_d  = cfg_fstep_q;
        cfg_dwell_d  = cfg_dwell_q;

        if (abort) begin
            // Abort wins over a simultaneous start; pword keeps its value.
            state_d = StIdle;
            fword_d = '0;
            cnt_d   = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (start_ok) begin
                            cfg_mode_d   = mode;
                            cfg_fstart_d = f_start;
                            cfg_fstop_d  = f_stop;
                            cfg_fstep_d  = f_step;
                            cfg_dwell_d  = dwell;
                            state_d      = StUp;
                            fword_d      = f_start;
                            pword_d      = pword_in;
                            cnt_d        = dwell;
                            busy_d       = 1'b1;
                            strobe_d     = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StUp, StDown: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CntOne;
                    end else begin
                        cnt_d = cfg_dwell_q;
                        if (state_q == StUp) begin
                            if (up_ok) begin
                                fword_d  = up_sum[DEPTH_BITWIDTH-1:0];
                                strobe_d = 1'b1;
                            end else begin
                                case (cfg_mode_q)
                                    2'd0: begin
                                        state_d = StIdle;
                                        busy_d  = 1'b0;
                                        done_d  = 1'b1;
                                    end
                                    2'd1: begin
                                        fword_d  = cfg_fstart_q;
                                        strobe_d = 1'b1;
                                    end
                                    default: begin
                                        state_d  = StDown;
                                        fword_d  = down_ok ? down_diff : cfg_fstart_q;
                                        strobe_d = 1'b1;
                                    end
                                endcase
                            end
                        end else begin
                            strobe_d = 1'b1;
                            if (down_ok) begin
                                fword_d = down_diff;
                            end else begin
                                state_d = StUp;
                                fword_d = up_ok ? up_sum[DEPTH_BITWIDTH-1:0] : cfg_fstop_q;
                            end
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            fword_q      <= '0;
            pword_q      <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            strobe_q     <= 1'b0;
            cfg_mode_q   <= '0;
            cfg_fstart_q <= '0;
            cfg_fstop_q  <= '0;
            cfg_fstep_q  <= '0;
            cfg_dwell_q  <= '0;
        end else begin
            state_q      <= state_d;
            fword_q      <= fword_d;
            pword_q      <= pword_d;
            cnt_q        <= cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            strobe_q     <= strobe_d;
            cfg_mode_q   <= cfg_mode_d;
            cfg_fstart_q <= cfg_fstart_d;
            cfg_fstop_q  <= cfg_fstop_d;
            cfg_fstep_q  <= cfg_fstep_d;
            cfg_dwell_q  <= cfg_dwell_d;
        end
    end

    assign fword       = fword_q;
    assign pword       = pword_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign step_strobe = strobe_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: self-checking bench for dds_sweep_ctrl (default widths 8/16).
// Start-acceptance table, hand-written corner sequences, and randomized sweeps checked
// against a frequency-list model (each list entry held dwell+1 cycles).
module tb_dds_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rstn, start, abort;
    logic [1:0] mode;
    logic [7:0] f_start, f_stop, f_step, pword_in;
    logic [15:0] dwell;
    logic [7:0] fword, pword;
    logic       busy, done, err, step_strobe;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(
        .DEPTH_BITWIDTH(8),
        .DWELL_BITWIDTH(16)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_step     (f_step),
        .dwell      (dwell),
        .pword_in   (pword_in),
        .fword      (fword),
        .pword      (pword),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .step_strobe(step_strobe)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_seq[$];

    typedef struct {
        int mode;
        int fs;
        int fe;
        int st;
        int dw;
        int pw;
        bit exp_err;
    } vec_t;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_out(input string name, input int fw, input int pw, input int b,
                             input int d, input int e, input int s);
        chk({name, ".fword"}, int'(fword), fw);
        chk({name, ".pword"}, int'(pword), pw);
        chk({name, ".busy"}, int'(busy), b);
        chk({name, ".done"}, int'(done), d);
        chk({name, ".err"}, int'(err), e);
        chk({name, ".step_strobe"}, int'(step_strobe), s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int m, input int fs, input int fe, input int st,
                           input int dw, input int pw);
        mode     = 2'(m);
        f_start  = 8'(fs);
        f_stop   = 8'(fe);
        f_step   = 8'(st);
        dwell    = 16'(dw);
        pword_in = 8'(pw);
    endtask

    // Sequence of distinct frequency holds, built from the sweep rules with plain integers.
    task automatic gen_seq(input int m, input int fs, input int fe, input int st,
                           input int maxlen);
        int v;
        bit up;
        exp_seq.delete();
        v  = fs;
        up = 1'b1;
        if (m == 0) begin
            while (v <= fe) begin
                exp_seq.push_back(v);
                v += st;
            end
        end else begin
            while (exp_seq.size() < maxlen) begin
                exp_seq.push_back(v);
                if (m == 1) begin
                    v = (v + st <= fe) ? v + st : fs;
                end else if (up) begin
                    if (v + st <= fe) v = v + st;
                    else begin
                        up = 1'b0;
                        v  = (v - st > fs) ? v - st : fs;
                    end
                end else begin
                    if (v - st >= fs) v = v - st;
                    else begin
                        up = 1'b1;
                        v  = (v + st < fe) ? v + st : fe;
                    end
                end
            end
        end
    endtask

    // Starts a valid sweep from IDLE and checks it cycle by cycle. Modes 1/2 run for
    // 'cycles' cycles and are then aborted. With 'disturb' set, config inputs and start
    // are scrambled during the sweep.
    task automatic run_sweep(input string name, input int m, input int fs, input int fe,
                             input int st, input int dw, input int pw, input int cycles,
                             input bit disturb);
        int total;
        int last;
        gen_seq(m, fs, fe, st, cycles / (dw + 1) + 2);
        total = (m == 0) ? exp_seq.size() * (dw + 1) : cycles;
        set_cfg(m, fs, fe, st, dw, pw);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < total; c++) begin
            check_out(name, exp_seq[c / (dw + 1)], pw, 1, 0, 0, (c % (dw + 1) == 0) ? 1 : 0);
            if (disturb) begin
                set_cfg($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
                        $urandom_range(0, 255), $urandom_range(0, 5), $urandom_range(0, 255));
                start = 1'($urandom_range(0, 1));
            end
            tick();
        end
        start = 1'b0;
        if (m == 0) begin
            last = exp_seq[exp_seq.size() - 1];
            check_out({name, ".end"}, last, pw, 0, 1, 0, 0);
            tick();
            check_out({name, ".after"}, last, pw, 0, 0, 0, 0);
        end else begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check_out({name, ".abort"}, 0, pw, 0, 0, 0, 0);
        end
    endtask

    initial begin
        vec_t tbl[8];
        int   r31[12];
        int   r32[8];
        int   strobes;
        int   last_fw;
        int   last_pw;

        tbl[0] = '{mode: 0, fs: 10,  fe: 40,  st: 10,  dw: 2, pw: 5, exp_err: 1'b0};
        tbl[1] = '{mode: 0, fs: 10,  fe: 40,  st: 0,   dw: 2, pw: 6, exp_err: 1'b1};
        tbl[2] = '{mode: 0, fs: 9,   fe: 5,   st: 1,   dw: 0, pw: 7, exp_err: 1'b1};
        tbl[3] = '{mode: 3, fs: 10,  fe: 40,  st: 10,  dw: 2, pw: 8, exp_err: 1'b1};
        tbl[4] = '{mode: 1, fs: 7,   fe: 7,   st: 3,   dw: 1, pw: 9, exp_err: 1'b0};
        tbl[5] = '{mode: 2, fs: 0,   fe: 255, st: 255, dw: 0, pw: 1, exp_err: 1'b0};
        tbl[6] = '{mode: 3, fs: 0,   fe: 0,   st: 0,   dw: 0, pw: 2, exp_err: 1'b1};
        tbl[7] = '{mode: 1, fs: 255, fe: 255, st: 1,   dw: 0, pw: 3, exp_err: 1'b0};
        r31 = '{10, 10, 10, 20, 20, 20, 30, 30, 30, 40, 40, 40};
        r32 = '{0, 10, 20, 10, 0, 10, 20, 10};

        rstn  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check_out("reset", 0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
        tick();

        // Start acceptance table
        last_fw = 0;
        last_pw = 0;
        foreach (tbl[i]) begin
            set_cfg(tbl[i].mode, tbl[i].fs, tbl[i].fe, tbl[i].st, tbl[i].dw, tbl[i].pw);
            start = 1'b1;
            tick();
            start = 1'b0;
            if (tbl[i].exp_err)
                check_out($sformatf("tbl%0d", i), last_fw, last_pw, 0, 0, 1, 0);
            else
                check_out($sformatf("tbl%0d", i), tbl[i].fs, tbl[i].pw, 1, 0, 0, 1);
            tick();
            chk($sformatf("tbl%0d.err_pulse", i), int'(err), 0);
            if (!tbl[i].exp_err) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check_out($sformatf("tbl%0d.abort", i), 0, tbl[i].pw, 0, 0, 0, 0);
                last_fw = 0;
                last_pw = tbl[i].pw;
            end
        end

        // Single up-ramp with explicit expected words
        set_cfg(0, 10, 40, 10, 2, 33);
        start = 1'b1;
        tick();
        start = 1'b0;
        strobes = 0;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("ramp.fword%0d", c), int'(fword), r31[c]);
            chk($sformatf("ramp.busy%0d", c), int'(busy), 1);
            chk($sformatf("ramp.done%0d", c), int'(done), 0);
            strobes += int'(step_strobe);
            tick();
        end
        chk("ramp.strobes", strobes, 4);
        check_out("ramp.done", 40, 33, 0, 1, 0, 0);
        tick();
        check_out("ramp.hold", 40, 33, 0, 0, 0, 0);

        // Triangle, dwell 0
        set_cfg(2, 0, 20, 10, 0, 44);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check_out($sformatf("tri%0d", c), r32[c], 44, 1, 0, 0, 1);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_out("tri.abort", 0, 44, 0, 0, 0, 0);

        // Sawtooth near the top of the word range must not wrap
        set_cfg(1, 250, 255, 10, 0, 55);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check_out($sformatf("nowrap%0d", c), 250, 55, 1, 0, 0, 1);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_out("nowrap.abort", 0, 55, 0, 0, 0, 0);

        // Start together with abort in IDLE
        set_cfg(0, 10, 40, 10, 2, 66);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_out("start_abort", 0, 55, 0, 0, 0, 0);

        // Start while busy with a different config is ignored
        run_sweep("busy_start", 0, 10, 40, 10, 2, 66, 0, 1'b1);

        // Reset during the 5th busy cycle, overriding a pending start
        set_cfg(0, 10, 40, 10, 2, 77);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        rstn  = 1'b0;
        start = 1'b1;
        tick();
        rstn  = 1'b1;
        start = 1'b0;
        check_out("midreset", 0, 0, 0, 0, 0, 0);
        tick();
        run_sweep("post_reset", 0, 10, 40, 10, 2, 77, 0, 1'b0);

        // f_start == f_stop in every mode
        run_sweep("flat0", 0, 100, 100, 5, 3, 1, 0, 1'b0);
        run_sweep("flat1", 1, 100, 100, 5, 2, 2, 12, 1'b0);
        run_sweep("flat2", 2, 100, 100, 5, 1, 3, 12, 1'b0);

        // Randomized sweeps against the model
        for (int it = 0; it < 40; it++) begin
            int m, fs, fe, st, dw, pw;
            m  = $urandom_range(0, 2);
            fs = $urandom_range(0, 255);
            fe = $urandom_range(fs, 255);
            st = $urandom_range(1, 80);
            dw = $urandom_range(0, 3);
            pw = $urandom_range(0, 255);
            if ($urandom_range(0, 4) == 0) begin
                // Rejected start: state and words unchanged, err pulses
                case ($urandom_range(0, 2))
                    0: set_cfg(m, fs, fe, 0, dw, pw);
                    1: set_cfg(m, 200, $urandom_range(0, 199), st, dw, pw);
                    default: set_cfg(3, fs, fe, st, dw, pw);
                endcase
                last_fw = int'(fword);
                last_pw = int'(pword);
                start = 1'b1;
                tick();
                start = 1'b0;
                check_out($sformatf("rnd%0d.reject", it), last_fw, last_pw, 0, 0, 1, 0);
                tick();
            end else begin
                run_sweep($sformatf("rnd%0d", it), m, fs, fe, st, dw, pw,
                          $urandom_range(10, 60), 1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
